// File: rtl/mbist_pkg.sv
// mbist_pkg: shared defaults and types for the MBIST datapath
package mbist_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int RD_LAT_MAX = 4;
  localparam int FAIL_CNT_W = 8;
  typedef struct packed {
    logic                  vld;
    logic                  exp;
    logic [ADDR_W_DEF-1:0] addr;
  } pipe_ent_t;
endpackage

// File: rtl/mbist_datapath_rd_pipe.sv
// mbist_rd_pipe: LAT-deep delay line whose entries (valid included) clear on rst
module mbist_rd_pipe #(
  parameter int W   = 2,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] pipe_q [LAT];
  logic [W-1:0] pipe_d [LAT];
  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < LAT; i++) pipe_q[i] <= rst ? '0 : pipe_d[i];
  end
  assign dout = pipe_q[LAT-1];
endmodule

// File: rtl/mbist_datapath.sv
// mbist_datapath: BIST address counter, strobes and latency-aligned compare; MBIST_FAIL_LOG_EN adds a fail log
module mbist_datapath
  import mbist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reset,
  input  logic              preset,
  input  logic              en,
  input  logic              up_down,
  input  logic              read,
  input  logic              write,
  input  logic              data,
  output logic              carry,
  output logic              is_equal,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MBIST_FAIL_LOG_EN
  ,
  input  logic                  clr_log,
  output logic                  fail_vld,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic [FAIL_CNT_W-1:0] fail_cnt
`endif
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cmp_vld, cmp_exp;
  always_comb begin
    addr_d = reset ? '0 : preset ? '1 : en ? (up_down ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1)) : addr_q;
  end
  always_ff @(posedge clk) begin
    addr_q <= rst ? '0 : addr_d;
  end
  assign carry     = up_down ? (addr_q == '1) : (addr_q == '0);
  assign mem_addr  = addr_q;
  assign mem_we    = write & en;
  assign mem_re    = read & en;
  assign mem_wdata = {DATA_W{data}};
  assign is_equal  = !(cmp_vld && mem_rdata != {DATA_W{cmp_exp}});
`ifdef MBIST_FAIL_LOG_EN
  localparam int PW = ADDR_W + 2;
  logic [PW-1:0]         pipe_in, pipe_out;
  logic [ADDR_W-1:0]     cmp_addr;
  logic                  fail_vld_q, fail_vld_d;
  logic [ADDR_W-1:0]     fail_addr_q, fail_addr_d;
  logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  assign pipe_in = {mem_re, data, addr_q};
  assign {cmp_vld, cmp_exp, cmp_addr} = pipe_out;
  always_comb begin
    fail_vld_d  = clr_log ? 1'b0 : fail_vld_q | ~is_equal;
    fail_addr_d = clr_log ? '0 : (~is_equal && !fail_vld_q) ? cmp_addr : fail_addr_q;
    fail_cnt_d  = clr_log ? '0 : (~is_equal && fail_cnt_q != '1) ? fail_cnt_q + FAIL_CNT_W'(1) : fail_cnt_q;
  end
  always_ff @(posedge clk) begin
    fail_vld_q  <= rst ? 1'b0 : fail_vld_d;
    fail_addr_q <= rst ? '0 : fail_addr_d;
    fail_cnt_q  <= rst ? '0 : fail_cnt_d;
  end
  assign fail_vld  = fail_vld_q;
  assign fail_addr = fail_addr_q;
  assign fail_cnt  = fail_cnt_q;
`else
  localparam int PW = 2;
  logic [PW-1:0] pipe_in, pipe_out;
  assign pipe_in = {mem_re, data};
  assign {cmp_vld, cmp_exp} = pipe_out;
`endif
  mbist_rd_pipe #(.W(PW), .LAT(RD_LAT)) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (pipe_in),
    .dout (pipe_out)
  );
endmodule
